// File: rtl/forwarding_scoreboard.sv
// EX-stage MEM/WB bypass selection plus a per-register scoreboard that stalls
// decode until every used source operand is forwardable.
module forwarding_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LAT_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  rs_id,
  input  logic [NUM_SRC-1:0]             rs_id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  rs_ex,
  input  logic [REG_ADDR_W-1:0]          rd_mem,
  input  logic                           regWriteMem,
  input  logic [REG_ADDR_W-1:0]          rd_wb,
  input  logic                           regWriteWb,
  input  logic                           issue_valid,
  input  logic [REG_ADDR_W-1:0]          issue_rd,
  input  logic [LAT_W-1:0]               issue_lat,
  input  logic                           complete_valid,
  input  logic [REG_ADDR_W-1:0]          complete_rd,
  input  logic                           flush,
  output logic [2*NUM_SRC-1:0]           forward,
  output logic                           stall,
  output logic [(2**REG_ADDR_W)-1:0]     busy_vec
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [LAT_W-1:0] LAT_INF = '1;

  logic [NUM_REGS-1:0] busy;
  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_SRC-1:0]  src_stall;
  logic                iss;

  genvar i;
  for (i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] id_rs;
    assign ex_rs = rs_ex[i*REG_ADDR_W +: REG_ADDR_W];
    assign id_rs = rs_id[i*REG_ADDR_W +: REG_ADDR_W];

    // MEM holds the younger result, so it beats WB for the same register.
    assign forward[2*i +: 2] =
      (regWriteMem && rd_mem != '0 && rd_mem == ex_rs) ? 2'b10 :
      (regWriteWb  && rd_wb  != '0 && rd_wb  == ex_rs) ? 2'b01 : 2'b00;

    assign src_stall[i] = rs_id_valid[i] && id_rs != '0 && busy[id_rs] &&
                          cnt[id_rs] != '0;
  end

  assign stall    = |src_stall;
  assign iss      = issue_valid && !stall && !flush && issue_rd != '0;
  assign busy_vec = busy;

  // Priority per entry: flush, issue, completion, then WB release / countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (flush) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (iss && issue_rd == REG_ADDR_W'(r)) begin
          busy[r] <= 1'b1;
          cnt[r]  <= issue_lat;
        end else if (complete_valid && complete_rd == REG_ADDR_W'(r)) begin
          cnt[r] <= '0;
        end else begin
          if (regWriteWb && rd_wb == REG_ADDR_W'(r) && cnt[r] == '0)
            busy[r] <= 1'b0;
          if (cnt[r] != '0 && cnt[r] != LAT_INF)
            cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised successor to the combinational EX-stage forwarding logic. It keeps the MEM/WB bypass selection, generalised to `NUM_SRC` source operands with correct MEM-over-WB priority. It adds a per-register scoreboard that tracks in-flight producers with fixed or variable result latency (loads, multiplier, divider) and raises a stall while any consumer operand is not yet forwardable. It sits between decode (issue/consume), the EX operand muxes, and the MEM/WB pipeline registers.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register address width; `NUM_REGS = 2**REG_ADDR_W`.
- `NUM_SRC`, 2: number of source operands checked per cycle.
- `LAT_W`, 3: latency counter width. `LAT_INF = 2**LAT_W-1` means variable latency.

Ports:
- `clk`, input, 1: clock; single clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rs_id`, input, `NUM_SRC*REG_ADDR_W`: source registers of the instruction in decode; field i is at `[i*REG_ADDR_W +: REG_ADDR_W]`.
- `rs_id_valid`, input, `NUM_SRC`: per-source "operand is used".
- `rs_ex`, input, `NUM_SRC*REG_ADDR_W`: source registers of the instruction in EX.
- `rd_mem`, input, `REG_ADDR_W`: MEM-stage destination.
- `regWriteMem`, input, 1: MEM-stage writes a register.
- `rd_wb`, input, `REG_ADDR_W`: WB-stage destination.
- `regWriteWb`, input, 1: WB-stage writes a register.
- `issue_valid`, input, 1: decode issues a register-writing instruction this cycle.
- `issue_rd`, input, `REG_ADDR_W`: its destination.
- `issue_lat`, input, `LAT_W`: stall cycles a consumer needs; 0 means fully forwardable; `LAT_INF` means variable.
- `complete_valid`, input, 1: variable-latency unit result is now forwardable.
- `complete_rd`, input, `REG_ADDR_W`: destination of the completing result.
- `flush`, input, 1: pipeline flush.
- `forward`, output, `2*NUM_SRC`: per-source select; 00 regfile, 10 MEM, 01 WB.
- `stall`, output, 1: hold decode.
- `busy_vec`, output, `NUM_REGS`: registered busy bits, for debug.

## Operation
- **State:** per register, `busy` (1 bit) and `cnt` (`LAT_W` bits). Register 0 is never busy.
- **Forwarding (combinational), per source i with rs = `rs_ex` field i:**
  - 10 if `regWriteMem`, `rd_mem` != 0 and `rd_mem` == rs.
  - Otherwise 01 if `regWriteWb`, `rd_wb` != 0 and `rd_wb` == rs.
  - Otherwise 00.
  - MEM has priority over WB.
- **Stall (combinational):** `stall` = OR over i of (`rs_id_valid[i]` && rs != 0 && `busy[rs]` && `cnt[rs]` != 0).
- **Effective issue:** `iss` = `issue_valid` && !`stall` && !`flush` && `issue_rd` != 0.
- **Per-entry update each edge, highest priority first:**
  - `flush`: `busy` = 0, `cnt` = 0 for all entries.
  - `iss` and r == `issue_rd`: `busy` = 1, `cnt` = `issue_lat`.
  - `complete_valid` and r == `complete_rd`: `cnt` = 0.
  - `regWriteWb` and r == `rd_wb` and `cnt[r]` == 0: `busy` = 0.
  - `cnt` != 0 and `cnt` != `LAT_INF`: `cnt` decrements by 1.
- **Simultaneous events:**
  - Issue and WB to the same r: issue wins; the entry stays busy.
  - Issue and complete to the same r: issue wins.
  - A complete to a non-busy entry is harmless.
- **Invalid source fields:** `rs_id_valid` = 0 sources never stall.

## Timing
- **Reset:** on `rst_n` low, immediately and asynchronously, all `busy` and `cnt` clear and `busy_vec` = 0. With all inputs 0, `forward` = 0 and `stall` = 0. Reset mid-countdown drops all pending state.
- **Latency-L issue (1 ≤ L < `LAT_INF`) at cycle t:**
  - A consumer in decode sees `stall` high in cycles t+1 .. t+L.
  - `stall` is low at t+L+1.
- **`issue_lat` = 0:** sets `busy` but never stalls.
- **`LAT_INF` issue:** stalls until the cycle after `complete_valid`. `cnt` holds indefinitely without completion.
- `forward` and `stall` have zero-cycle latency from their inputs. `busy_vec` reflects state after the edge.
- `issue_valid` while `stall` is high is ignored; decode re-presents the instruction.

## Test plan
- **Reset:** assert `rst_n` low mid-countdown (`cnt[5]` = 3) → `busy_vec` = 0 and `stall` = 0 with no clock edge.
- **MEM/WB priority:** `rd_mem` = `rd_wb` = 7, both write enables set, `rs_ex` = {7,7} → `forward` = {10,10}. With `rd_mem` = 0 and the same WB → {01,01}.
- **Fixed latency:** issue x3 with lat 2 at t; consumer `rs_id` = {3,0} valid → `stall` = 1 at t+1 and t+2, 0 at t+3. An `issue_valid` at t+1 is ignored.
- **Variable latency:** issue x9 with `LAT_INF`; hold 10 cycles → `stall` stays 1. Pulse `complete_valid`/`complete_rd` = 9 → `stall` = 0 the next cycle.
- **Same-register events:** same-cycle issue x4 (lat 3) and `regWriteWb` `rd_wb` = 4 → x4 stays busy with `cnt` = 3. Issue to x0 → no state change.
- **Flush:** flush during a pending lat-5 load on x12 with a simultaneous issue x13 → both entries clear and `stall` = 0 the next cycle.
